intdiv_otf_conv: RTL and testbench



---
 rtl/intdiv_pkg.sv | 21 ++
 rtl/intdiv_otf_conv_if.sv | 25 ++
 rtl/intdiv_otf_step.sv | 35 +++
 rtl/intdiv_otf_conv.sv | 96 +++++++++
 tb/tb_intdiv_otf_conv.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/intdiv_pkg.sv
// Shared definitions for the intdiv on-the-fly quotient converter:
// SD2 digit encodings, converter states and the digit-counter width helper.
package intdiv_pkg;

    localparam logic [1:0] NEG1   = 2'b11;
    localparam logic [1:0] ZERO   = 2'b00;
    localparam logic [1:0] POS1_1 = 2'b01;
    localparam logic [1:0] POS1_2 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..n inclusive; keep at least one bit for tiny n.
    function automatic int cnt_width(input int n);
        return (n + 1 <= 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/intdiv_otf_conv_if.sv
// Digit-in / quotient-out handshake bundle between the divider, the
// on-the-fly converter and the quotient consumer.
interface intdiv_otf_conv_if #(
    parameter int N = 4
);
    logic       start;
    logic       d_valid;
    logic       d_ready;
    logic [1:0] d;
    logic       q_valid;
    logic       q_ready;
    logic [N:0] q;
    logic [N:0] qm;
    logic       busy;

    modport master (
        output start, d_valid, d, q_ready,
        input  d_ready, q_valid, q, qm, busy
    );

    modport slave (
        input  start, d_valid, d, q_ready,
        output d_ready, q_valid, q, qm, busy
    );
endinterface

// File: rtl/intdiv_otf_step.sv
// Combinational single-digit on-the-fly update of the (Q, QM) pair:
// each result is a one-bit left shift of Q or QM with a new low bit.
module intdiv_otf_step
    import intdiv_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   d,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    logic neg;
    logic zero;
    logic pos;

    assign neg  = (d == NEG1);
    assign zero = (d == ZERO);
    // Both 2'b01 and 2'b10 decode to +1.
    assign pos  = !neg && !zero;

    // +1: Q'=2Q+1, QM'=2Q;  0: Q'=2Q, QM'=2QM+1;  -1: Q'=2QM+1, QM'=2QM.
    assign q_next[0]  = pos || neg;
    assign qm_next[0] = zero;

    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_shift
            assign q_next[gi]  = neg ? qm[gi-1] : q[gi-1];
            assign qm_next[gi] = pos ? q[gi-1]  : qm[gi-1];
        end
    endgenerate

endmodule

// File: rtl/intdiv_otf_conv.sv
// Sequential SD2-to-two's-complement on-the-fly converter: accepts N digits
// MSD first, keeps Q and QM=Q-1 registered and presents both on a handshake.
module intdiv_otf_conv
    import intdiv_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    intdiv_otf_conv_if.slave bus
);

    localparam int              W    = N + 1;
    localparam int              CW   = cnt_width(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   q_reg;
    logic [W-1:0]   q_next;
    logic [W-1:0]   qm_reg;
    logic [W-1:0]   qm_next;
    logic [CW-1:0]  cnt_reg;
    logic [CW-1:0]  cnt_next;

    logic [W-1:0]   q_step;
    logic [W-1:0]   qm_step;

    intdiv_otf_step #(
        .W (W)
    ) u_step (
        .q       (q_reg),
        .qm      (qm_reg),
        .d       (bus.d),
        .q_next  (q_step),
        .qm_next (qm_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            qm_reg    <= '1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            qm_reg    <= qm_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        qm_next    = qm_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                // Result of the previous conversion stays visible until reload.
                if (bus.start) begin
                    q_next     = '0;
                    qm_next    = '1;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.d_valid) begin
                    q_next   = q_step;
                    qm_next  = qm_step;
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.q_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.d_ready = (state_reg == RUN);
    assign bus.q_valid = (state_reg == DONE);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.q       = q_reg;
    assign bus.qm      = qm_reg;

endmodule

// File: tb/tb_intdiv_otf_conv.sv
// Directed bench for intdiv_otf_conv (N=4): hand-computed quotients, stalls,
// backpressure, mid-conversion reset and back-to-back random streams.
module tb_intdiv_otf_conv;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    intdiv_otf_conv_if #(.N(N)) bus ();

    intdiv_otf_conv #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Digits packed MSD first in dg[7:6]; gap idle cycles (with start pulses)
    // before digit 3; hold cycles of q_ready low (with start pulses) in DONE.
    task automatic convert(input string tag, input logic [7:0] dg, input int gap,
                           input int hold, input int expv);
        logic [4:0] eq;
        logic [4:0] eqm;
        eq  = expv[4:0];
        eqm = eq - 5'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_run_rdy"}, 32'(bus.d_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (i == 2) begin
                for (int k = 0; k < gap; k++) begin
                    bus.d_valid = 1'b0;
                    bus.start   = 1'b1;
                    @(negedge clk);
                    bus.start   = 1'b0;
                end
            end
            bus.d_valid = 1'b1;
            bus.d       = dg[7-2*i -: 2];
            @(negedge clk);
        end
        bus.d_valid = 1'b0;
        check({tag, "_qvalid"}, 32'(bus.q_valid), 32'd1);
        check({tag, "_q"}, 32'(bus.q), 32'(eq));
        check({tag, "_qm"}, 32'(bus.qm), 32'(eqm));
        check({tag, "_drdy_done"}, 32'(bus.d_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            bus.start = k[0];
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.q_valid), 32'd1);
            check({tag, "_hold_q"}, 32'({bus.q, bus.qm}), 32'({eq, eqm}));
        end
        bus.start   = 1'b0;
        bus.q_ready = 1'b1;
        @(negedge clk);
        bus.q_ready = 1'b0;
        check({tag, "_qvalid_drop"}, 32'(bus.q_valid), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_q_idle_hold"}, 32'(bus.q), 32'(eq));
    endtask

    initial begin
        logic [7:0] rd;
        int         model;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.d_valid = 1'b0;
        bus.d       = 2'b00;
        bus.q_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_drdy", 32'(bus.d_ready), 32'd0);
        check("rst_qvalid", 32'(bus.q_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_qm", 32'(bus.qm), 32'h1f);
        rst_n = 1'b1;
        // d_valid in IDLE must not disturb anything.
        bus.d_valid = 1'b1;
        bus.d       = 2'b01;
        @(negedge clk);
        bus.d_valid = 1'b0;
        check("idle_ignore_d", 32'({bus.busy, bus.q}), 32'd0);

        // +1 0 -1 +1 = 8 - 2 + 1 = 7
        convert("s1",      8'b01_00_11_01, 0, 0, 7);
        convert("neg15",   8'b11_11_11_11, 0, 0, -15);
        convert("zero",    8'b00_00_00_00, 0, 0, 0);
        convert("s1_p10",  8'b10_00_11_10, 0, 0, 7);
        convert("s1_mix",  8'b10_00_11_01, 0, 0, 7);
        convert("gap",     8'b01_00_11_01, 3, 0, 7);
        convert("bp",      8'b01_00_11_01, 0, 5, 7);
        convert("mix2",    8'b11_01_10_00, 0, 0, -2);

        // Reset after two accepted digits.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.d_valid = 1'b1;
        bus.d       = 2'b01;
        repeat (2) @(negedge clk);
        bus.d_valid = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_q", 32'(bus.q), 32'd0);
        check("mid_rst_qm", 32'(bus.qm), 32'h1f);
        check("mid_rst_qvalid", 32'(bus.q_valid), 32'd0);
        check("mid_rst_drdy", 32'(bus.d_ready), 32'd0);
        convert("pos15",   8'b01_01_01_01, 0, 0, 15);

        // Back-to-back random streams against sum d_i * 2^(N-1-i).
        for (int t = 0; t < 12; t++) begin
            model = 0;
            for (int i = 0; i < N; i++) begin
                rd[7-2*i -: 2] = 2'($urandom_range(0, 3));
                case (rd[7-2*i -: 2])
                    2'b11:   model = model * 2 - 1;
                    2'b00:   model = model * 2;
                    default: model = model * 2 + 1;
                endcase
            end
            convert($sformatf("rnd%0d", t), rd, 0, 0, model);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
